// File: rtl/pd_readout_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pd_readout_sequencer                                                     |
// | Steps each enabled photodiode channel through reset, integrate,          |
// | sample-hold and compare phases and captures the comparator result.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pd_readout_sequencer #(
  parameter int          N_CH          = 12,
  parameter int          CNT_W         = 8,
  parameter logic [15:0] FRAME_CNT_RST = 16'h0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cont_i,
  input  logic [N_CH-1:0]  ch_mask_i,
  input  logic [CNT_W-1:0] t_rst_i,
  input  logic [CNT_W-1:0] t_int_i,
  input  logic [CNT_W-1:0] t_sh_i,
  input  logic [CNT_W-1:0] t_cmp_i,
  input  logic             cmp_i,
  output logic             sh_rst_o,
  output logic             sh_o,
  output logic             sh_cmp_o,
  output logic [N_CH-1:0]  pd_a_o,
  output logic [N_CH-1:0]  pd_b_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [N_CH-1:0]  result_o,
  output logic [15:0]      frame_cnt_o
);

  localparam int c_ch_w = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    c_st_idle = 3'd0,
    c_st_rst  = 3'd1,
    c_st_int  = 3'd2,
    c_st_sh   = 3'd3,
    c_st_cmp  = 3'd4,
    c_st_next = 3'd5,
    c_st_fin  = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [c_ch_w-1:0]   r_ch;
  logic [c_ch_w-1:0]   w_ch_nx;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic                r_cmp_meta;
  logic                r_cmp_sync;
  logic [N_CH-1:0]     r_shadow;
  logic [N_CH-1:0]     w_above;
  logic [N_CH-1:0]     w_ch_onehot;
  logic                w_phase_end;
  logic                w_mask_any;
  logic                w_abort;
  logic                w_frame_start;

  // Zero-length phases still occupy one cycle.
  function automatic logic [CNT_W-1:0] f_dur(input logic [CNT_W-1:0] t);
    return (t == '0) ? CNT_W'(1) : t;
  endfunction

  function automatic logic [c_ch_w-1:0] f_first(input logic [N_CH-1:0] v);
    logic [c_ch_w-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = c_ch_w'(i);
    end
    return idx;
  endfunction

  function automatic logic [N_CH-1:0] f_onehot(input logic [c_ch_w-1:0] ch);
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) begin
      v[i] = (c_ch_w'(i) == ch);
    end
    return v;
  endfunction

  always_comb begin
    w_above = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_above[i] = ch_mask_i[i] && (i > int'(r_ch));
    end
  end

  assign w_mask_any    = |ch_mask_i;
  assign w_phase_end   = (r_cnt <= CNT_W'(1));
  assign w_abort       = abort_i && (r_state != c_st_idle);
  assign w_frame_start = ((r_state == c_st_idle) && start_i) || (r_state == c_st_fin);
  assign w_ch_onehot   = f_onehot(w_ch_nx);

  always_comb begin
    w_state_nx = r_state;
    w_ch_nx    = r_ch;
    w_cnt_nx   = r_cnt;
    case (r_state)
      c_st_idle: begin
        if (start_i) begin
          if (w_mask_any) begin
            w_state_nx = c_st_rst;
            w_ch_nx    = f_first(ch_mask_i);
            w_cnt_nx   = f_dur(t_rst_i);
          end else begin
            w_state_nx = c_st_fin;
          end
        end
      end
      c_st_rst: begin
        if (w_phase_end) begin
          w_state_nx = c_st_int;
          w_cnt_nx   = f_dur(t_int_i);
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      c_st_int: begin
        if (w_phase_end) begin
          w_state_nx = c_st_sh;
          w_cnt_nx   = f_dur(t_sh_i);
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      c_st_sh: begin
        if (w_phase_end) begin
          w_state_nx = c_st_cmp;
          w_cnt_nx   = f_dur(t_cmp_i);
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      c_st_cmp: begin
        if (w_phase_end) begin
          w_state_nx = c_st_next;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      c_st_next: begin
        if (|w_above) begin
          w_state_nx = c_st_rst;
          w_ch_nx    = f_first(w_above);
          w_cnt_nx   = f_dur(t_rst_i);
        end else begin
          w_state_nx = c_st_fin;
        end
      end
      c_st_fin: begin
        if (cont_i && w_mask_any) begin
          w_state_nx = c_st_rst;
          w_ch_nx    = f_first(ch_mask_i);
          w_cnt_nx   = f_dur(t_rst_i);
        end else begin
          w_state_nx = c_st_idle;
        end
      end
      default: w_state_nx = c_st_idle;
    endcase
    if (w_abort) w_state_nx = c_st_idle;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= c_st_idle;
      r_ch        <= '0;
      r_cnt       <= '0;
      r_cmp_meta  <= 1'b0;
      r_cmp_sync  <= 1'b0;
      r_shadow    <= '0;
      sh_rst_o    <= 1'b0;
      sh_o        <= 1'b0;
      sh_cmp_o    <= 1'b0;
      pd_a_o      <= '0;
      pd_b_o      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      result_o    <= '0;
      frame_cnt_o <= FRAME_CNT_RST;
    end else begin
      r_cmp_meta <= cmp_i;
      r_cmp_sync <= r_cmp_meta;
      r_state    <= w_state_nx;
      r_ch       <= w_ch_nx;
      r_cnt      <= w_cnt_nx;
      sh_rst_o   <= (w_state_nx == c_st_rst);
      sh_o       <= (w_state_nx == c_st_sh);
      sh_cmp_o   <= (w_state_nx == c_st_cmp);
      pd_b_o     <= (w_state_nx == c_st_rst) ? w_ch_onehot : '0;
      pd_a_o     <= ((w_state_nx == c_st_int) || (w_state_nx == c_st_sh)) ? w_ch_onehot : '0;
      busy_o     <= (w_state_nx != c_st_idle);
      done_o     <= (w_state_nx == c_st_fin);
      if (w_abort) begin
        r_shadow <= '0;
      end else begin
        if (r_state == c_st_fin) begin
          result_o    <= r_shadow;
          frame_cnt_o <= frame_cnt_o + 16'd1;
        end
        // Shadow is cleared per frame, so channels never visited read 0.
        if (w_frame_start) begin
          r_shadow <= '0;
        end else if ((r_state == c_st_cmp) && w_phase_end) begin
          r_shadow[r_ch] <= r_cmp_sync;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pd_readout_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_pd_readout_sequencer                                                  |
// | Directed, table-driven bench for the photodiode readout sequencer.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pd_readout_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_i, abort_i, cont_i, cmp_i;
  logic [11:0] ch_mask_i;
  logic [7:0]  t_rst_i, t_int_i, t_sh_i, t_cmp_i;
  logic        sh_rst_o, sh_o, sh_cmp_o, busy_o, done_o;
  logic [11:0] pd_a_o, pd_b_o, result_o;
  logic [15:0] frame_cnt_o;

  // Small second instance with a preloaded frame counter to reach the wrap.
  logic        w2_start;
  logic [3:0]  w2_mask;
  logic        w2_sh_rst, w2_sh, w2_sh_cmp, w2_busy, w2_done;
  logic [3:0]  w2_pd_a, w2_pd_b, w2_result;
  logic [15:0] w2_frame_cnt;

  pd_readout_sequencer #(.N_CH(12), .CNT_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .abort_i(abort_i),
    .cont_i(cont_i), .ch_mask_i(ch_mask_i), .t_rst_i(t_rst_i), .t_int_i(t_int_i),
    .t_sh_i(t_sh_i), .t_cmp_i(t_cmp_i), .cmp_i(cmp_i), .sh_rst_o(sh_rst_o),
    .sh_o(sh_o), .sh_cmp_o(sh_cmp_o), .pd_a_o(pd_a_o), .pd_b_o(pd_b_o),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .frame_cnt_o(frame_cnt_o)
  );

  pd_readout_sequencer #(.N_CH(4), .CNT_W(8), .FRAME_CNT_RST(16'hFFFF)) dut_wrap (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(w2_start), .abort_i(1'b0),
    .cont_i(1'b0), .ch_mask_i(w2_mask), .t_rst_i(8'd0), .t_int_i(8'd0),
    .t_sh_i(8'd0), .t_cmp_i(8'd0), .cmp_i(1'b0), .sh_rst_o(w2_sh_rst),
    .sh_o(w2_sh), .sh_cmp_o(w2_sh_cmp), .pd_a_o(w2_pd_a), .pd_b_o(w2_pd_b),
    .busy_o(w2_busy), .done_o(w2_done), .result_o(w2_result), .frame_cnt_o(w2_frame_cnt)
  );

  typedef struct {
    logic [11:0] mask;
    logic [7:0]  tr, ti, ts, tc;
    logic [11:0] pat;
    int          exp_len;
    logic [11:0] exp_res;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic int invariant_viol(input logic [11:0] mask);
    logic [11:0] pd;
    int v;
    pd = pd_a_o | pd_b_o;
    v  = 0;
    if ($countones(pd) > 1) v++;
    if ($countones({sh_rst_o, sh_o, sh_cmp_o}) > 1) v++;
    if ((pd & ~mask) != 12'h0) v++;
    return v;
  endfunction

  // Present the channel's comparator level while its reset switch is closed.
  task automatic drive_cmp(input logic [11:0] pat);
    if (pd_b_o != 12'h0) cmp_i = |(pd_b_o & pat);
  endtask

  task automatic run_frame(input string name, input logic [11:0] mask,
                           input logic [7:0] tr, input logic [7:0] ti,
                           input logic [7:0] ts, input logic [7:0] tc,
                           input logic [11:0] pat, input int exp_len,
                           input logic [11:0] exp_res);
    int len, viol, pulses;
    logic prev_rst, got;
    logic [11:0] lowest;
    @(negedge clk);
    ch_mask_i = mask; t_rst_i = tr; t_int_i = ti; t_sh_i = ts; t_cmp_i = tc;
    cont_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lowest = mask & (~mask + 12'd1);
    check({name, " first sh_rst"}, 32'(sh_rst_o), 32'(mask != 12'h0));
    check({name, " first pd_b"}, 32'(pd_b_o), 32'(lowest));
    len = 1; viol = 0; pulses = 0; prev_rst = 1'b0; got = 1'b0;
    while (len <= 3000) begin
      viol += invariant_viol(mask);
      if (sh_rst_o && !prev_rst) pulses++;
      prev_rst = sh_rst_o;
      drive_cmp(pat);
      if (done_o) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      len++;
    end
    check({name, " frame length"}, got ? 32'(len) : 32'hFFFF_FFFF, 32'(exp_len));
    check({name, " invariants"}, 32'(viol), 32'd0);
    check({name, " channel slots"}, 32'(pulses), 32'($countones(mask)));
    @(negedge clk);
    exp_frames++;
    check({name, " idle after"}, {30'd0, busy_o, done_o}, 32'd0);
    check({name, " result"}, 32'(result_o), 32'(exp_res));
    check({name, " frame_cnt"}, 32'(frame_cnt_o), 32'(exp_frames[15:0]));
  endtask

  initial begin
    int cyc, ndone, d[3];
    logic found, saw_done;
    logic [11:0] res_before;
    logic [15:0] cnt_before;

    vecs[0] = '{12'hFFF, 8'd2,   8'd2,   8'd2,   8'd2,   12'hAAA, 109,  12'hAAA};
    vecs[1] = '{12'h011, 8'd0,   8'd0,   8'd0,   8'd0,   12'h010, 11,   12'h010};
    vecs[2] = '{12'h000, 8'd0,   8'd0,   8'd0,   8'd0,   12'hFFF, 1,    12'h000};
    vecs[3] = '{12'h800, 8'd1,   8'd3,   8'd0,   8'd5,   12'hFFF, 12,   12'h800};
    vecs[4] = '{12'h001, 8'd255, 8'd255, 8'd255, 8'd255, 12'h001, 1022, 12'h001};
    vecs[5] = '{12'hFFF, 8'd0,   8'd1,   8'd0,   8'd1,   12'h555, 61,   12'h555};

    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; cont_i = 1'b0; cmp_i = 1'b0;
    ch_mask_i = 12'h0; t_rst_i = 8'd0; t_int_i = 8'd0; t_sh_i = 8'd0; t_cmp_i = 8'd0;
    w2_start = 1'b0; w2_mask = 4'h0;
    repeat (3) @(negedge clk);
    check("reset controls", {sh_rst_o, sh_o, sh_cmp_o, busy_o, done_o, pd_a_o, pd_b_o}, 32'd0);
    check("reset result", 32'(result_o), 32'd0);
    check("reset frame_cnt", 32'(frame_cnt_o), 32'd0);
    rst_n = 1'b1;

    // Frame counter wrap on the preloaded instance.
    check("wrap preload", 32'(w2_frame_cnt), 32'h0000_FFFF);
    @(negedge clk); w2_start = 1'b1;
    @(negedge clk); w2_start = 1'b0;
    check("wrap empty frame", {30'd0, w2_busy, w2_done}, 32'd3);
    @(negedge clk);
    check("wrap frame_cnt", 32'(w2_frame_cnt), 32'd0);

    for (int v = 0; v < 6; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].mask, vecs[v].tr, vecs[v].ti,
                vecs[v].ts, vecs[v].tc, vecs[v].pat, vecs[v].exp_len, vecs[v].exp_res);
    end

    // Continuous mode: three frames back to back.
    @(negedge clk);
    ch_mask_i = 12'h011; t_rst_i = 8'd0; t_int_i = 8'd0; t_sh_i = 8'd0; t_cmp_i = 8'd0;
    cont_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1; ndone = 0; d = '{0, 0, 0};
    while (cyc < 200) begin
      drive_cmp(12'h001);
      if (done_o) begin
        d[ndone] = cyc;
        ndone++;
        if (ndone == 3) begin
          cont_i = 1'b0;
          break;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("cont done count", 32'(ndone), 32'd3);
    check("cont first done", 32'(d[0]), 32'd11);
    check("cont spacing 1", 32'(d[1] - d[0]), 32'd11);
    check("cont spacing 2", 32'(d[2] - d[1]), 32'd11);
    @(negedge clk);
    exp_frames += 3;
    check("cont stop", {30'd0, busy_o, done_o}, 32'd0);
    check("cont frame_cnt", 32'(frame_cnt_o), 32'(exp_frames[15:0]));
    check("cont result", 32'(result_o), 32'h001);

    // Abort during the sample-hold phase of channel 5.
    res_before = result_o; cnt_before = frame_cnt_o;
    @(negedge clk);
    ch_mask_i = 12'hFFF; t_rst_i = 8'd2; t_int_i = 8'd2; t_sh_i = 8'd2; t_cmp_i = 8'd2;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    found = 1'b0; saw_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive_cmp(12'hFFF);
      if (done_o) saw_done = 1'b1;
      if (sh_o && pd_a_o[5]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort reach SH ch5", 32'(found), 32'd1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort outputs low", {sh_rst_o, sh_o, sh_cmp_o, busy_o, done_o, pd_a_o, pd_b_o}, 32'd0);
    check("abort result kept", 32'(result_o), 32'(res_before));
    check("abort frame_cnt kept", 32'(frame_cnt_o), 32'(cnt_before));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done_o || busy_o) saw_done = 1'b1;
    end
    check("abort no done", 32'(saw_done), 32'd0);

    // Shadow bits from the aborted frame must not leak into the next one.
    run_frame("post-abort", 12'h020, 8'd0, 8'd0, 8'd0, 8'd0, 12'h000, 6, 12'h000);

    // Asynchronous reset in the middle of a compare phase.
    @(negedge clk);
    ch_mask_i = 12'hFFF; t_rst_i = 8'd2; t_int_i = 8'd2; t_sh_i = 8'd2; t_cmp_i = 8'd2;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive_cmp(12'hFFF);
      if (sh_cmp_o) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reset reach CMP", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset controls", {sh_rst_o, sh_o, sh_cmp_o, busy_o, done_o, pd_a_o, pd_b_o}, 32'd0);
    check("async reset frame_cnt", 32'(frame_cnt_o), 32'd0);
    exp_frames = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("post-reset", 12'h0C0, 8'd1, 8'd1, 8'd1, 8'd1, 12'h040, 11, 12'h040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
